alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execution stage directly downstream of the 8x16 internal register file. Consumes the two read-port operands (ra/rb) plus a 3-bit opcode and produces a registered result and flags. That result feeds back to the register file write-data input.
- Single-cycle logic/arith/shift ops.
- Iterative shift-add multiplier (multi-cycle) with busy/valid handshake.

Parameters:
WIDTH, 16, operand/result width in bits (power of two, >=8)
SHW, $clog2(WIDTH), shift-amount field width taken from op_b LSBs

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only while busy=0
opcode  input  3  operation select (see Behaviour)
op_a  input  WIDTH  operand A (regfile ra output)
op_b  input  WIDTH  operand B (regfile rb output)
result  output  WIDTH  registered result, held until next completion
result_valid  output  1  one-cycle pulse when result/flags update
busy  output  1  multiply in progress; start ignored
flag_zero  output  1  result==0
flag_neg  output  1  result[WIDTH-1]
flag_carry  output  1  carry/borrow/shift-out/mul-overflow

Behaviour:
- Reset (async, any state incl. mid-multiply):
  - state->IDLE.
  - result, result_valid, busy and all flags = 0.
  - Multiplier accumulator/counter cleared.
- Opcodes:
  - 000 ADD; 001 SUB (a-b); 010 AND; 011 OR; 100 XOR.
  - 101 SHL a by b[SHW-1:0]; 110 SHR logical a by b[SHW-1:0].
  - 111 MUL, low WIDTH bits of a*b, unsigned.
- Operands and opcode are captured on the accepting edge only. Later changes on op_a/op_b are ignored.
- FSM states: IDLE, MUL.
  - IDLE + start + opcode!=111: result/flags registered at that edge; result_valid=1 for the following cycle (latency 1). Stay IDLE.
  - IDLE + start + opcode=111: load multiplicand/multiplier, counter=0; ->MUL. busy=1 from next cycle.
  - MUL: one multiplier bit per cycle (shift-add, 2*WIDTH accumulator). After WIDTH iterations: write result/flags, result_valid=1, busy=0, ->IDLE. Latency WIDTH+1 edges from accept to result_valid.
  - start while busy=1: ignored, no queueing.
  - start in the cycle result_valid is high (busy=0): accepted normally; back-to-back allowed.
- Carry rules:
  - ADD: carry-out.
  - SUB: borrow (a<b unsigned).
  - SHL/SHR: last bit shifted out; shift amount 0 -> 0.
  - AND/OR/XOR: 0.
  - MUL: 1 if upper WIDTH bits of the full product are non-zero.
- result_valid low in every other cycle.
- result and flags are held between completions.
- No X propagation: undefined opcodes do not exist (3 bits fully decoded).

Optional Feature:
Macro ALU_OVERFLOW_FLAG_EN.
- Defined: extra output flag_ovf (1 bit, reset 0), updated with result_valid.
  - ADD: signed overflow (operands same sign, result sign differs).
  - SUB: signed overflow (operands differ in sign, result sign differs from a).
  - All other ops: 0.
- Undefined: port absent, no overflow logic; all other behaviour identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_ADD..OP_MUL).
  - FSM state encoding (ST_IDLE, ST_MUL).
  - Default WIDTH constant.
- One sub-module, seq_multiplier:
  - Inputs: clock, reset, load, a, b.
  - Outputs: done pulse, product[2*WIDTH-1:0].
  - Owns the counter and accumulator.
- alu_exec_stage holds the FSM, the single-cycle datapath and the flag/result registers.

Test Plan:
1. Reset, then ADD a=0xFFFF b=0x0001 start -> next cycle result=0x0000, zero=1, carry=1, neg=0, result_valid 1 cycle.
2. SUB a=0x0003 b=0x0005 -> result=0xFFFE, carry=1 (borrow), neg=1. SHL a=0x8001 b=1 -> result=0x0002, carry=1.
3. MUL a=0x0123 b=0x0010 -> busy high 16 cycles, result_valid at edge 17, result=0x1230, carry=0. MUL a=0x1000 b=0x0010 -> result=0x0000, zero=1, carry=1.
4. During MUL, pulse start with ADD, and change op_a/op_b mid-multiply -> ADD ignored, MUL result unaffected. Start with XOR 0x00FF^0x0F0F in the result_valid cycle -> 0x0FF0 one cycle later.
5. Assert reset asynchronously mid-MUL (cycle 8) -> busy/result/flags 0 immediately. After release, idle until next start.
6. With ALU_OVERFLOW_FLAG_EN: ADD 0x7FFF+0x0001 -> result=0x8000, flag_ovf=1. SUB 0x8000-0x0001 -> 0x7FFF, flag_ovf=1. AND -> flag_ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the ALU execution stage
// Purpose: opcode encodings, FSM state encoding and default datapath width
//          shared by alu_exec_stage and seq_multiplier.
// Ports: none (package).
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative unsigned shift-add multiplier
// Purpose: multiplies a*b one multiplier bit per clock, WIDTH iterations.
// Ports:
//   clock, reset  rising-edge clock, async active-high reset
//   load          capture a (multiplicand) and b (multiplier), restart count
//   a, b          operands, sampled only when load=1
//   done          high during the cycle whose edge completes the last iteration
//   product       full 2*WIDTH product; meaningful only while done=1
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               running;
  logic [WIDTH:0]     partial;
  logic [2*WIDTH-1:0] acc_next;

  // acc = {partial product high half, remaining multiplier bits}. Each step adds
  // the multiplicand into the high half when the current multiplier LSB is set,
  // then shifts the whole accumulator (including the add carry) right by one.
  always_comb begin
    partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_next = {partial, acc[WIDTH-1:1]};
  end

  // product is the post-iteration value so the caller can register it on the
  // same edge that finishes the last iteration.
  assign done    = running && (count == CW'(WIDTH-1));
  assign product = acc_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      acc     <= '0;
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      mcand   <= a;
      acc     <= {{WIDTH{1'b0}}, b};
      count   <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc   <= acc_next;
      count <= count + CW'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execution stage with iterative multiplier
// Purpose: single-cycle ADD/SUB/AND/OR/XOR/SHL/SHR and multi-cycle MUL, with a
//          registered result and flags feeding the register file write port.
// Optional: define ALU_OVERFLOW_FLAG_EN to add the signed-overflow output flag_ovf.
// Ports:
//   clock, reset   rising-edge clock, async active-high reset
//   start          request, sampled only while busy=0
//   opcode         operation select (alu_pkg OP_*)
//   op_a, op_b     operands from register file read ports
//   result         registered result, held between completions
//   result_valid   one-cycle pulse when result/flags update
//   busy           multiply in progress, start ignored
//   flag_zero, flag_neg, flag_carry (and flag_ovf when enabled)
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_carry
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic             flag_ovf
`endif
);

  alu_state_t state, state_next;
  logic       mul_load;
  logic       alu_commit;
  logic       mul_commit;

  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_product;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [WIDTH-1:0] commit_res;
  logic             commit_carry;

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (mul_load),
    .a       (op_a),
    .b       (op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    mul_load   = 1'b0;
    alu_commit = 1'b0;
    mul_commit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mul_load   = 1'b1;
            state_next = ST_MUL;
          end else begin
            alu_commit = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          mul_commit = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_MUL);

  // Extra MSB/LSB on the shift operands catches the last bit shifted out; a
  // zero shift amount leaves that bit at 0, giving carry=0.
  assign shamt    = op_b[SHW-1:0];
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
  assign shl_ext  = {1'b0, op_a} << shamt;
  assign shr_ext  = {op_a, 1'b0} >> shamt;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (opcode)
      OP_ADD: {alu_carry, alu_res} = sum_ext;
      OP_SUB: {alu_carry, alu_res} = diff_ext;
      OP_AND: alu_res = op_a & op_b;
      OP_OR:  alu_res = op_a | op_b;
      OP_XOR: alu_res = op_a ^ op_b;
      OP_SHL: {alu_carry, alu_res} = shl_ext;
      OP_SHR: begin
        alu_res   = shr_ext[WIDTH:1];
        alu_carry = shr_ext[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    commit_res   = alu_res;
    commit_carry = alu_carry;
    if (mul_commit) begin
      commit_res   = mul_product[WIDTH-1:0];
      commit_carry = |mul_product[2*WIDTH-1:WIDTH];
    end
  end

`ifdef ALU_OVERFLOW_FLAG_EN
  logic alu_ovf;

  always_comb begin
    alu_ovf = 1'b0;
    if (opcode == OP_ADD) begin
      alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
    end else if (opcode == OP_SUB) begin
      alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_ovf <= 1'b0;
    end else if (alu_commit) begin
      flag_ovf <= alu_ovf;
    end else if (mul_commit) begin
      flag_ovf <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result       <= '0;
      result_valid <= 1'b0;
      flag_zero    <= 1'b0;
      flag_neg     <= 1'b0;
      flag_carry   <= 1'b0;
    end else begin
      result_valid <= alu_commit | mul_commit;
      if (alu_commit | mul_commit) begin
        result     <= commit_res;
        flag_zero  <= (commit_res == '0);
        flag_neg   <= commit_res[WIDTH-1];
        flag_carry <= commit_carry;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage
`timescale 1ns/1ps
module tb_alu_exec_stage;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] result;
  logic         result_valid;
  logic         busy;
  logic         flag_zero;
  logic         flag_neg;
  logic         flag_carry;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic         flag_ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int edges;
  int busy_cycles;
  int seen_valid;
  int seen_busy;

  always #5 clock = ~clock;

  alu_exec_stage #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .op_a         (op_a),
    .op_b         (op_b),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg),
    .flag_carry   (flag_carry)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .flag_ovf     (flag_ovf)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request at the falling edge; return 1ns after the accepting edge.
  task automatic issue(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    start  = 1'b1;
    opcode = opc;
    op_a   = a;
    op_b   = b;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] res, input logic z, input logic n, input logic c);
    check({tag, ".valid"}, {31'd0, result_valid}, 32'd1);
    check({tag, ".result"}, {16'd0, result}, {16'd0, res});
    check({tag, ".znc"}, {29'd0, flag_zero, flag_neg, flag_carry}, {29'd0, z, n, c});
  endtask

  // Count edges after the accept edge until result_valid; optionally inject an
  // ADD request plus operand changes at edge index inject_at while busy.
  task automatic wait_valid(input int inject_at, output int n_edges, output int n_busy);
    n_edges = 0;
    n_busy  = 0;
    while (result_valid !== 1'b1 && n_edges < 40) begin
      if (busy === 1'b1) n_busy++;
      @(negedge clock);
      if (n_edges == inject_at) begin
        start  = 1'b1;
        opcode = OP_ADD;
        op_a   = 16'hAAAA;
        op_b   = 16'h5555;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      n_edges++;
    end
    start = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'b000;
    op_a   = '0;
    op_b   = '0;
    #1;
    check("reset.result", {16'd0, result}, 32'd0);
    check("reset.valid", {31'd0, result_valid}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.znc", {29'd0, flag_zero, flag_neg, flag_carry}, 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("reset.ovf", {31'd0, flag_ovf}, 32'd0);
`endif
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    issue(OP_ADD, 16'hFFFF, 16'h0001);
    expect_out("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

    issue(OP_SUB, 16'h0003, 16'h0005);
    expect_out("sub_borrow", 16'hFFFE, 1'b0, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    check("sub_borrow.pulse", {31'd0, result_valid}, 32'd0);
    check("sub_borrow.hold", {16'd0, result}, 32'h0000_FFFE);
    check("sub_borrow.busy", {31'd0, busy}, 32'd0);

    issue(OP_SHL, 16'h8001, 16'h0001);
    expect_out("shl1", 16'h0002, 1'b0, 1'b0, 1'b1);
    issue(OP_SHL, 16'hC003, 16'h0012);
    expect_out("shl_lsb_amt", 16'h000C, 1'b0, 1'b0, 1'b1);
    issue(OP_SHR, 16'h8001, 16'h0001);
    expect_out("shr1", 16'h4000, 1'b0, 1'b0, 1'b1);
    issue(OP_SHR, 16'h00F0, 16'h0010);
    expect_out("shr0", 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(OP_SHL, 16'h8000, 16'h0000);
    expect_out("shl0", 16'h8000, 1'b0, 1'b1, 1'b0);
    issue(OP_AND, 16'hF0F0, 16'h0FF0);
    expect_out("and", 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(OP_OR, 16'hF000, 16'h000F);
    expect_out("or", 16'hF00F, 1'b0, 1'b1, 1'b0);
    issue(OP_SUB, 16'h0005, 16'h0005);
    expect_out("sub_eq", 16'h0000, 1'b1, 1'b0, 1'b0);

    issue(OP_ADD, 16'h7FFF, 16'h0001);
    expect_out("add_sovf", 16'h8000, 1'b0, 1'b1, 1'b0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("add_sovf.ovf", {31'd0, flag_ovf}, 32'd1);
`endif
    issue(OP_SUB, 16'h8000, 16'h0001);
    expect_out("sub_sovf", 16'h7FFF, 1'b0, 1'b0, 1'b0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("sub_sovf.ovf", {31'd0, flag_ovf}, 32'd1);
`endif
    issue(OP_AND, 16'h8000, 16'hFFFF);
    expect_out("and_neg", 16'h8000, 1'b0, 1'b1, 1'b0);
`ifdef ALU_OVERFLOW_FLAG_EN
    check("and_neg.ovf", {31'd0, flag_ovf}, 32'd0);
`endif

    issue(OP_MUL, 16'h0123, 16'h0010);
    check("mul1.busy", {31'd0, busy}, 32'd1);
    check("mul1.novalid", {31'd0, result_valid}, 32'd0);
    wait_valid(-1, edges, busy_cycles);
    check("mul1.latency", edges, 32'd16);
    check("mul1.busy_cycles", busy_cycles, 32'd16);
    expect_out("mul1", 16'h1230, 1'b0, 1'b0, 1'b0);
    check("mul1.busy_end", {31'd0, busy}, 32'd0);

    issue(OP_MUL, 16'h1000, 16'h0010);
    check("mul2.accept", {31'd0, busy}, 32'd1);
    wait_valid(-1, edges, busy_cycles);
    check("mul2.latency", edges, 32'd16);
    expect_out("mul2", 16'h0000, 1'b1, 1'b0, 1'b1);

    issue(OP_MUL, 16'h0123, 16'h0010);
    wait_valid(3, edges, busy_cycles);
    check("mul_inj.latency", edges, 32'd16);
    expect_out("mul_inj", 16'h1230, 1'b0, 1'b0, 1'b0);
    issue(OP_XOR, 16'h00FF, 16'h0F0F);
    expect_out("xor_b2b", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    check("xor_b2b.busy", {31'd0, busy}, 32'd0);

    issue(OP_MUL, 16'h0123, 16'h0010);
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.busy", {31'd0, busy}, 32'd0);
    check("async_rst.result", {16'd0, result}, 32'd0);
    check("async_rst.valid", {31'd0, result_valid}, 32'd0);
    check("async_rst.znc", {29'd0, flag_zero, flag_neg, flag_carry}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    seen_valid = 0;
    seen_busy  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (result_valid === 1'b1) seen_valid++;
      if (busy === 1'b1) seen_busy++;
    end
    check("post_rst.idle_valid", seen_valid, 32'd0);
    check("post_rst.idle_busy", seen_busy, 32'd0);

    issue(OP_ADD, 16'h0002, 16'h0003);
    expect_out("post_rst.add", 16'h0005, 1'b0, 1'b0, 1'b0);
    issue(OP_MUL, 16'h0003, 16'h0005);
    wait_valid(-1, edges, busy_cycles);
    check("post_rst.mul_latency", edges, 32'd16);
    expect_out("post_rst.mul", 16'h000F, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
